// File: rtl/ga_timebase_pkg.sv
// Shared definitions for the GA generation timebase: phase codes, FSM states
// and default widths.
package ga_timebase_pkg;

    localparam int DIV_W_DEF    = 16;
    localparam int GEN_W_DEF    = 16;
    localparam int TO_TICKS_DEF = 1024;
    localparam int TO_W_DEF     = 11;

    localparam logic [1:0] PH_SELECT = 2'd0;
    localparam logic [1:0] PH_CROSS  = 2'd1;
    localparam logic [1:0] PH_MUTATE = 2'd2;
    localparam logic [1:0] PH_EVAL   = 2'd3;
    localparam logic [1:0] PH_LAST   = PH_EVAL;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PH_START,
        ST_PH_WAIT,
        ST_GEN_END,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ga_prescaler.sv
// Programmable tick divider: one-cycle strobe every div_l enabled cycles.
// Dropping en clears the count, so every enable window starts from zero.
module ga_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_l,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic             at_last;

    // div_l is expected to be at least 1; the caller clamps a zero divisor.
    assign at_last = (count_reg == (div_l - DIV_W'(1)));
    assign tick    = en && at_last;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_reg <= '0;
        end else if (at_last) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ga_timebase.sv
// Generation sequencer for the GA datapath: walks SELECT/CROSS/MUTATE/EVAL on
// prescaler ticks, handshakes with stage_done, counts generations, flags stalls.
module ga_timebase
    import ga_timebase_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int GEN_W    = GEN_W_DEF,
    parameter int TO_TICKS = TO_TICKS_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [GEN_W-1:0] max_gen,
    input  logic             stage_done,
    output logic             tick,
    output logic [1:0]       phase,
    output logic             phase_start,
    output logic             phase_valid,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             run_done,
    output logic             timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

    state_t           state_reg;
    logic [DIV_W-1:0] div_l_reg;
    logic [GEN_W-1:0] max_gen_l_reg;
    logic [GEN_W-1:0] gen_count_reg;
    logic [GEN_W-1:0] gen_next;
    logic [1:0]       phase_reg;
    logic [TO_W-1:0]  to_count_reg;
    logic             phase_start_reg;
    logic             phase_valid_reg;
    logic             busy_reg;
    logic             run_done_reg;
    logic             timeout_err_reg;
    logic             tick_int;

    ga_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (busy_reg),
        .div_l (div_l_reg),
        .tick  (tick_int)
    );

    // gen_count never exceeds max_gen_l, so this increment cannot wrap.
    assign gen_next = gen_count_reg + GEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            div_l_reg       <= '0;
            max_gen_l_reg   <= '0;
            gen_count_reg   <= '0;
            phase_reg       <= PH_SELECT;
            to_count_reg    <= '0;
            phase_start_reg <= 1'b0;
            phase_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            run_done_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            phase_start_reg <= 1'b0;
            run_done_reg    <= 1'b0;
            if (stop && (state_reg != ST_IDLE)) begin
                state_reg       <= ST_IDLE;
                busy_reg        <= 1'b0;
                phase_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            div_l_reg       <= (div == '0) ? DIV_W'(1) : div;
                            max_gen_l_reg   <= max_gen;
                            gen_count_reg   <= '0;
                            phase_reg       <= PH_SELECT;
                            timeout_err_reg <= 1'b0;
                            busy_reg        <= 1'b1;
                            if (max_gen == '0) begin
                                state_reg    <= ST_DONE;
                                run_done_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_PH_START;
                            end
                        end
                    end
                    ST_PH_START: begin
                        if (tick_int) begin
                            phase_start_reg <= 1'b1;
                            phase_valid_reg <= 1'b1;
                            to_count_reg    <= '0;
                            state_reg       <= ST_PH_WAIT;
                        end
                    end
                    ST_PH_WAIT: begin
                        // A completing stage beats a timeout landing in the same cycle.
                        if (stage_done) begin
                            phase_valid_reg <= 1'b0;
                            if (phase_reg != PH_LAST) begin
                                phase_reg <= phase_reg + 2'd1;
                                state_reg <= ST_PH_START;
                            end else begin
                                state_reg <= ST_GEN_END;
                            end
                        end else if (tick_int) begin
                            if (to_count_reg == TO_LAST) begin
                                timeout_err_reg <= 1'b1;
                                busy_reg        <= 1'b0;
                                phase_valid_reg <= 1'b0;
                                state_reg       <= ST_IDLE;
                            end else begin
                                to_count_reg <= to_count_reg + TO_W'(1);
                            end
                        end
                    end
                    ST_GEN_END: begin
                        gen_count_reg <= gen_next;
                        if (gen_next == max_gen_l_reg) begin
                            state_reg    <= ST_DONE;
                            run_done_reg <= 1'b1;
                        end else begin
                            phase_reg <= PH_SELECT;
                            state_reg <= ST_PH_START;
                        end
                    end
                    ST_DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tick        = tick_int;
    assign phase       = phase_reg;
    assign phase_start = phase_start_reg;
    assign phase_valid = phase_valid_reg;
    assign gen_count   = gen_count_reg;
    assign busy        = busy_reg;
    assign run_done    = run_done_reg;
    assign timeout_err = timeout_err_reg;

endmodule
